// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 front end.
//   XLEN          : datapath width
//   NOP           : canonical no-op (addi x0, x0, 0) shown to decode when nothing is valid
//   fetch_state_e : fetch controller FSM states
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch stage for both the instruction buffer and the
// outstanding-address queue.
//   clk, rst     : clock, asynchronous active-low reset
//   push         : write push_data at the tail (accepted when not full, or full with pop)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; overrides push and pop
//   head         : current head entry (valid when !empty)
//   count        : number of stored entries
//   full, empty  : occupancy flags
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign head    = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_ctl.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction memory, buffers
// returned words with their PCs and presents one instruction per cycle to decode.
//   clk, rst                      : clock, asynchronous active-low reset
//   imem_req_valid/ready, addr    : request handshake to instruction memory
//   imem_rsp_valid, imem_rsp_data : in-order response words
//   pcSel, br_target              : redirect from execute
//   stall                         : decode cannot accept this cycle
//   inst, inst_pc, inst_valid     : instruction presented to decode
//   fetch_fault                   : sticky misaligned-redirect trap
module fetch_ctl
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            pcSel,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  output logic            fetch_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, held_addr_q;
  logic            held_q, stale_hold_q;
  logic [CW-1:0]   drop_cnt_q;

  logic [2*XLEN-1:0] iq_head;
  logic [CW-1:0]     iq_count, aq_count;
  logic              iq_full, iq_empty, aq_full, aq_empty;
  logic [XLEN-1:0]   aq_head;

  logic in_run, redirect, misaligned, deq, credit, accept, rsp, iq_push;
  logic unused_flags;

  assign in_run     = (state_q == StRun);
  assign redirect   = in_run & pcSel;
  assign misaligned = (br_target[1:0] != 2'b00);
  assign inst_valid = ~iq_empty;
  assign deq        = inst_valid & ~stall & ~pcSel;
  assign rsp        = imem_rsp_valid & ~aq_empty;

  // The entry decode takes this cycle frees a slot, which is what lets a 1-cycle memory
  // sustain one instruction per cycle with only two slots.
  assign credit = (32'(aq_count) + 32'(iq_count)) < (DEPTH + 32'(deq));

  // A request, once shown, is held until accepted. No new request is started while a redirect
  // is being taken, since it would be for the old path.
  assign imem_req_valid = held_q | (in_run & ~pcSel & credit);
  assign imem_addr      = held_q ? held_addr_q : pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // A response arriving with a redirect, or owed to an older path, never reaches decode.
  assign iq_push = rsp & in_run & ~pcSel & (drop_cnt_q == '0);

  assign inst    = iq_empty ? NOP  : iq_head[XLEN-1:0];
  assign inst_pc = iq_empty ? pc_q : iq_head[2*XLEN-1:XLEN];

  assign fetch_fault  = (state_q == StFault);
  assign unused_flags = iq_full ^ aq_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      held_q       <= 1'b0;
      held_addr_q  <= RESET_PC;
      stale_hold_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      held_q <= imem_req_valid & ~imem_req_ready;
      if (imem_req_valid) held_addr_q <= imem_addr;
      if (accept) stale_hold_q <= 1'b0;
      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          if (pcSel) begin
            if (misaligned) begin
              state_q <= StFault;
            end else begin
              pc_q         <= br_target;
              // Everything in flight plus a still-held request belongs to the old path.
              drop_cnt_q   <= CW'(32'(aq_count) + 32'(held_q) - 32'(rsp));
              stale_hold_q <= held_q & ~imem_req_ready;
            end
          end else begin
            // A stale held request was for the old path; pc already points at the target.
            if (accept && !stale_hold_q) pc_q <= pc_q + 32'd4;
            if (rsp && drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - CW'(1);
          end
        end
        StFault: state_q <= StFault;
        default: state_q <= StBoot;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * XLEN)
  ) u_inst_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (iq_push),
    .push_data({aq_head, imem_rsp_data}),
    .pop      (deq),
    .flush    (redirect),
    .head     (iq_head),
    .count    (iq_count),
    .full     (iq_full),
    .empty    (iq_empty)
  );

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(XLEN)
  ) u_addr_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_data(imem_addr),
    .pop      (rsp),
    .flush    (1'b0),
    .head     (aq_head),
    .count    (aq_count),
    .full     (aq_full),
    .empty    (aq_empty)
  );

endmodule

// File: tb/tb_fetch_ctl.sv
module tb_fetch_ctl;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr, imem_rsp_data, br_target, inst, inst_pc;
  logic        imem_rsp_valid, pcSel, stall, inst_valid, fetch_fault;

  fetch_ctl #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .pcSel         (pcSel),
    .br_target     (br_target),
    .stall         (stall),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  typedef struct {
    logic stall;
    logic exp_req;
    logic exp_iv;
  } vec_t;

  mem_t        memq[$];
  logic [31:0] sb[$];
  vec_t        tbl[15];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          consumed = 0;
  logic        ready_drv = 1'b1;
  logic        held_stale = 1'b0;
  logic        prev_held = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] next_req = '0;
  logic [31:0] last_pc = '0;
  logic        s_req, s_iv, s_fault, s_rsp;
  logic [31:0] s_addr, s_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: memory model drives a response, outputs are sampled, consumed
  // instructions are checked against the scoreboard, accepted requests enter the memory.
  task automatic cycle(input logic st, input logic ps, input logic [31:0] tgt);
    logic [31:0] exp;
    stall          = st;
    pcSel          = ps;
    br_target      = tgt;
    imem_req_ready = ready_drv;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr;
      void'(memq.pop_front());
    end
    #1;
    s_req   = imem_req_valid;
    s_addr  = imem_addr;
    s_iv    = inst_valid;
    s_inst  = inst;
    s_fault = fetch_fault;
    s_rsp   = imem_rsp_valid;
    if (prev_held) begin
      chk("held_valid", {31'b0, s_req}, 32'd1);
      chk("held_addr", s_addr, prev_addr);
    end
    if (s_iv && !st && !ps) begin
      consumed++;
      last_pc = inst_pc;
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk("inst_pc", inst_pc, exp);
      chk("inst", inst, exp);
    end
    if (s_req && ready_drv) begin
      chk("outstanding_le_depth", {31'b0, memq.size() < DEPTH}, 32'd1);
      memq.push_back('{addr: s_addr, due: cyc + lat});
      if (held_stale) begin
        held_stale = 1'b0;
      end else if (!ps) begin
        chk("req_addr", s_addr, next_req);
        sb.push_back(next_req);
        next_req = next_req + 32'd4;
      end
    end
    prev_held = s_req && !ready_drv;
    prev_addr = s_addr;
    if (ps) begin
      sb.delete();
      next_req = tgt;
      if (s_req && !ready_drv) held_stale = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset mid-cycle, check reset outputs, release at a falling edge (cycle 0).
  task automatic do_reset();
    stall          = 1'b0;
    pcSel          = 1'b0;
    br_target      = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #3 rst = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", inst, NOP_W);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    memq.delete();
    sb.delete();
    held_stale = 1'b0;
    prev_held  = 1'b0;
    next_req   = 32'h0;
    ready_drv  = 1'b1;
    lat        = 1;
    rst        = 1'b1;
    cyc        = 0;
  endtask

  task automatic wait_first(input string name, input logic [31:0] exp);
    int          c0 = consumed;
    logic [31:0] got = 32'hFFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (consumed != c0) begin
        got = last_pc;
        break;
      end
    end
    chk(name, got, exp);
  endtask

  initial begin
    // Straight-line fetch with a 5-cycle stall window (cycles 6..10).
    for (int i = 0; i < 15; i++) begin
      tbl[i].stall   = (i >= 6 && i <= 10);
      tbl[i].exp_req = (i >= 1 && i <= 5) || (i >= 11);
      tbl[i].exp_iv  = (i >= 3);
    end

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].stall, 1'b0, 32'h0);
      chk($sformatf("req_valid_c%0d", i), {31'b0, s_req}, {31'b0, tbl[i].exp_req});
      chk($sformatf("inst_valid_c%0d", i), {31'b0, s_iv}, {31'b0, tbl[i].exp_iv});
      if (!s_iv) chk("nop_when_empty", s_inst, NOP_W);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    lat = 3;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    chk("inflight_before_redirect", 32'(memq.size()), 32'd2);
    cycle(1'b0, 1'b1, 32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    chk("redirect_iv_next", {31'b0, s_iv}, 32'd0);
    wait_first("first_after_redirect", 32'h100);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect while the request for address 8 is held.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    ready_drv = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    chk("held_req_addr8", s_addr, 32'h8);
    cycle(1'b0, 1'b1, 32'h40);
    chk("held_across_redirect", s_addr, 32'h8);
    cycle(1'b0, 1'b0, 32'h0);
    ready_drv = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("stale_accepted_addr", s_addr, 32'h8);
    wait_first("first_after_held", 32'h40);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect, response and stall in the same cycle.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h200);
    chk("rsp_with_redirect", {31'b0, s_rsp}, 32'd1);
    cycle(1'b0, 1'b0, 32'h0);
    chk("empty_after_combo", {31'b0, s_iv}, 32'd0);
    wait_first("first_after_combo", 32'h200);

    // Misaligned redirect traps and stays trapped until reset.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h102);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      chk("fault_sticky", {31'b0, s_fault}, 32'd1);
      chk("no_req_in_fault", {31'b0, s_req}, 32'd0);
      chk("no_inst_in_fault", {31'b0, s_iv}, 32'd0);
    end
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    chk("fault_cleared", {31'b0, s_fault}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
